// File: rtl/rvfi_chk_pkg.sv
// Shared types for the RVFI retirement checker: error codes, FSM states,
// RV32 major opcodes and the source-operand usage decode.
// No logic, no latency, no flow control.
package rvfi_chk_pkg;

  typedef enum logic [3:0] {
    ERR_NONE         = 4'd0,
    ERR_PC_START     = 4'd1,
    ERR_PC_DISCONT   = 4'd2,
    ERR_RS1_MISMATCH = 4'd3,
    ERR_RS2_MISMATCH = 4'd4,
    ERR_X0_WRITE     = 4'd5,
    ERR_PC_MISALIGN  = 4'd6,
    ERR_MEM_MASK     = 4'd7
  } err_code_e;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Returns {rs1_used, rs2_used}. Unknown opcodes are treated as reading rs1
  // so that a garbage encoding still gets its rs1 report cross-checked.
  function automatic logic [1:0] src_used(input logic [6:0] opcode);
    logic rs1_used;
    logic rs2_used;
    rs1_used = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    rs2_used = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
    return {rs1_used, rs2_used};
  endfunction

endpackage

// File: rtl/rvfi_shadow_rf.sv
// Shadow integer register file x1..x31 (x0 reads as constant zero).
// Latency: reads combinational, writes visible the cycle after the edge.
// Backpressure: none, one write per cycle accepted unconditionally.
// Ports: clk, rst (sync active-low clear), rs1_addr/rs1_data and
// rs2_addr/rs2_data (async read), wr_en/wr_addr/wr_data (write port).
module rvfi_shadow_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= 32'h0;
    end else if (wr_en && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : regs[rs2_addr];

endmodule

// File: rtl/rvfi_retire_checker.sv
// RVFI retirement checker: shadow RF, PC continuity, operand and x0 checks,
// retire counter and sticky first-error record. Latency: error/count outputs
// update one cycle after the packet. Backpressure: none, one packet per cycle.
// Optional store-mask check compiled in with `define RVFI_CHK_MEM_EN.
// Ports: clk, rst (sync active-low), rvfi_* retirement packet inputs,
// retire_count, err_valid/err_code/err_pc/err_insn, halted.
module rvfi_retire_checker
  import rvfi_chk_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned CNT_W       = 32,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rvfi_valid,
  input  logic [31:0]      rvfi_insn,
  input  logic [4:0]       rvfi_rs1_addr,
  input  logic [4:0]       rvfi_rs2_addr,
  input  logic [31:0]      rvfi_rs1_rdata,
  input  logic [31:0]      rvfi_rs2_rdata,
  input  logic [4:0]       rvfi_rd_addr,
  input  logic [31:0]      rvfi_rd_wdata,
  input  logic [31:0]      rvfi_pc_rdata,
  input  logic [31:0]      rvfi_pc_wdata,
  input  logic [3:0]       rvfi_mem_wmask,
  output logic [CNT_W-1:0] retire_count,
  output logic             err_valid,
  output logic [3:0]       err_code,
  output logic [31:0]      err_pc,
  output logic [31:0]      err_insn,
  output logic             halted
);

  state_e      state_q, state_d;
  logic [31:0] expected_pc;
  logic [31:0] shadow_rs1, shadow_rs2;
  logic [6:0]  opcode;
  logic        rs1_used, rs2_used;
  logic        mem_ok;
  err_code_e   chk_code;
  logic        active, has_err, clean, resync;

  assign opcode               = rvfi_insn[6:0];
  assign {rs1_used, rs2_used} = src_used(opcode);

`ifdef RVFI_CHK_MEM_EN
  always_comb begin
    mem_ok = 1'b0;
    if (opcode == OPC_STORE) begin
      case (rvfi_insn[14:12])
        3'b000:  mem_ok = $onehot(rvfi_mem_wmask);
        3'b001:  mem_ok = (rvfi_mem_wmask == 4'b0011) || (rvfi_mem_wmask == 4'b1100);
        3'b010:  mem_ok = (rvfi_mem_wmask == 4'b1111);
        default: mem_ok = 1'b0;
      endcase
    end else begin
      mem_ok = (rvfi_mem_wmask == 4'b0000);
    end
  end
`else
  logic unused_wmask;
  assign unused_wmask = ^rvfi_mem_wmask;
  assign mem_ok       = 1'b1;
`endif

  // Priority cascade: the first failing check in code order is reported.
  always_comb begin
    chk_code = ERR_NONE;
    if (state_q == ST_FIRST && rvfi_pc_rdata != RESET_PC)
      chk_code = ERR_PC_START;
    else if (state_q == ST_RUN && rvfi_pc_rdata != expected_pc)
      chk_code = ERR_PC_DISCONT;
    else if (rs1_used && rvfi_rs1_rdata != shadow_rs1)
      chk_code = ERR_RS1_MISMATCH;
    else if (rs2_used && rvfi_rs2_rdata != shadow_rs2)
      chk_code = ERR_RS2_MISMATCH;
    else if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != 32'h0)
      chk_code = ERR_X0_WRITE;
    else if (rvfi_pc_wdata[1:0] != 2'b00)
      chk_code = ERR_PC_MISALIGN;
    else if (!mem_ok)
      chk_code = ERR_MEM_MASK;
  end

  assign active  = rvfi_valid && (state_q != ST_HALT);
  assign has_err = active && (chk_code != ERR_NONE);
  assign clean   = active && (chk_code == ERR_NONE);
  // In continue-on-error mode the trace is trusted to resynchronise the
  // shadow state, otherwise one bad packet would cascade into endless errors.
  assign resync  = clean || (has_err && !HALT_ON_ERR);

  rvfi_shadow_rf u_shadow (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rvfi_rs1_addr),
    .rs2_addr (rvfi_rs2_addr),
    .rs1_data (shadow_rs1),
    .rs2_data (shadow_rs2),
    .wr_en    (resync),
    .wr_addr  (rvfi_rd_addr),
    .wr_data  (rvfi_rd_wdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FIRST: begin
        if (has_err && HALT_ON_ERR) state_d = ST_HALT;
        else if (clean)             state_d = ST_RUN;
      end
      ST_RUN: begin
        if (has_err && HALT_ON_ERR) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_FIRST;
      expected_pc  <= RESET_PC;
      retire_count <= '0;
      err_valid    <= 1'b0;
      err_code     <= 4'd0;
      err_pc       <= 32'h0;
      err_insn     <= 32'h0;
    end else begin
      state_q <= state_d;
      if (clean)  retire_count <= retire_count + CNT_W'(1);
      if (resync) expected_pc  <= rvfi_pc_wdata;
      if (has_err && !err_valid) begin
        err_valid <= 1'b1;
        err_code  <= chk_code;
        err_pc    <= rvfi_pc_rdata;
        err_insn  <= rvfi_insn;
      end
    end
  end

  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_rvfi_retire_checker.sv
// Directed bench for rvfi_retire_checker: one halting instance and one
// continue-on-error instance (2-bit counter) driven by the same packet stream.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_rvfi_retire_checker;

  localparam logic [31:0] I_ADDI_X1_5 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD_X2    = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] I_ADD_X3    = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] I_LUI_X3    = 32'h1234_51B7; // lui  x3,0x12345
  localparam logic [31:0] I_ADDI_X0_1 = 32'h0010_0013; // addi x0,x0,1
  localparam logic [31:0] I_NOP       = 32'h0000_0013;
  localparam logic [31:0] I_SW        = 32'h0011_2023; // sw   x1,0(x2)

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic [31:0] rvfi_insn = '0;
  logic [4:0]  rvfi_rs1_addr = '0, rvfi_rs2_addr = '0, rvfi_rd_addr = '0;
  logic [31:0] rvfi_rs1_rdata = '0, rvfi_rs2_rdata = '0, rvfi_rd_wdata = '0;
  logic [31:0] rvfi_pc_rdata = '0, rvfi_pc_wdata = '0;
  logic [3:0]  rvfi_mem_wmask = '0;

  logic [31:0] h_count;
  logic        h_err_valid, h_halted;
  logic [3:0]  h_err_code;
  logic [31:0] h_err_pc, h_err_insn;
  logic [1:0]  c_count;
  logic        c_err_valid, c_halted;
  logic [3:0]  c_err_code;
  logic [31:0] c_err_pc, c_err_insn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rvfi_retire_checker #(.RESET_PC(32'h0), .CNT_W(32), .HALT_ON_ERR(1'b1)) u_halt (
    .clk(clk), .rst(rst), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_wmask(rvfi_mem_wmask), .retire_count(h_count),
    .err_valid(h_err_valid), .err_code(h_err_code), .err_pc(h_err_pc),
    .err_insn(h_err_insn), .halted(h_halted)
  );

  rvfi_retire_checker #(.RESET_PC(32'h0), .CNT_W(2), .HALT_ON_ERR(1'b0)) u_cont (
    .clk(clk), .rst(rst), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_wmask(rvfi_mem_wmask), .retire_count(c_count),
    .err_valid(c_err_valid), .err_code(c_err_code), .err_pc(c_err_pc),
    .err_insn(c_err_insn), .halted(c_halted)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Presents one packet for exactly one rising edge (unless followed by another send).
  task automatic send(input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] insn,
                      input logic [4:0] rs1a, input logic [31:0] rs1d,
                      input logic [4:0] rs2a, input logic [31:0] rs2d,
                      input logic [4:0] rda, input logic [31:0] rdd,
                      input logic [3:0] wmask);
    @(negedge clk);
    rvfi_valid = 1'b1; rvfi_pc_rdata = pc; rvfi_pc_wdata = npc; rvfi_insn = insn;
    rvfi_rs1_addr = rs1a; rvfi_rs1_rdata = rs1d; rvfi_rs2_addr = rs2a; rvfi_rs2_rdata = rs2d;
    rvfi_rd_addr = rda; rvfi_rd_wdata = rdd; rvfi_mem_wmask = wmask;
  endtask

  task automatic idle();
    @(negedge clk);
    rvfi_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; rvfi_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    check_eq("rst_h_count", h_count, 0);
    check_eq("rst_h_errv", h_err_valid, 0);
    check_eq("rst_h_code", h_err_code, 0);
    check_eq("rst_h_halted", h_halted, 0);
    check_eq("rst_c_count", c_count, 0);

    // Clean addi then add, with a gap in between, then back-to-back.
    send(32'h0, 32'h4, I_ADDI_X1_5, 5'd0, 32'd0, 5'd5, 32'd0, 5'd1, 32'd5, 4'h0);
    idle(); idle();
    send(32'h4, 32'h8, I_ADD_X2, 5'd1, 32'd5, 5'd1, 32'd5, 5'd2, 32'd10, 4'h0);
    send(32'h8, 32'hC, I_ADD_X3, 5'd1, 32'd5, 5'd2, 32'd10, 5'd3, 32'd15, 4'h0);
    idle();
    check_eq("clean_h_count", h_count, 3);
    check_eq("clean_h_errv", h_err_valid, 0);
    check_eq("clean_c_count", c_count, 3);

    // PC discontinuity on the second packet.
    do_reset();
    send(32'h0, 32'h4, I_ADDI_X1_5, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5, 4'h0);
    send(32'h8, 32'hC, I_ADD_X2, 5'd1, 32'd5, 5'd1, 32'd5, 5'd2, 32'd10, 4'h0);
    idle();
    check_eq("disc_h_code", h_err_code, 2);
    check_eq("disc_h_pc", h_err_pc, 32'h8);
    check_eq("disc_h_insn", h_err_insn, I_ADD_X2);
    check_eq("disc_h_halted", h_halted, 1);
    check_eq("disc_h_count", h_count, 1);
    check_eq("disc_c_code", c_err_code, 2);
    check_eq("disc_c_halted", c_halted, 0);
    // Continue-mode resynced expected_pc to 0xC from the bad packet.
    send(32'hC, 32'h10, I_ADDI_X1_5, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5, 4'h0);
    idle();
    check_eq("halt_frozen_count", h_count, 1);
    check_eq("resync_c_count", c_count, 2);

    // rs2 mismatch; LUI with garbage source reports is not an error.
    do_reset();
    send(32'h0, 32'h4, I_ADDI_X1_5, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5, 4'h0);
    send(32'h4, 32'h8, I_LUI_X3, 5'd1, 32'd99, 5'd1, 32'd7, 5'd3, 32'h1234_5000, 4'h0);
    idle();
    check_eq("lui_h_errv", h_err_valid, 0);
    check_eq("lui_h_count", h_count, 2);
    send(32'h8, 32'hC, I_ADD_X2, 5'd1, 32'd5, 5'd1, 32'd7, 5'd2, 32'd12, 4'h0);
    idle();
    check_eq("rs2_h_code", h_err_code, 4);
    check_eq("rs2_h_pc", h_err_pc, 32'h8);
    check_eq("rs2_h_count", h_count, 2);

    // rs1 outranks rs2 when both disagree.
    do_reset();
    send(32'h0, 32'h4, I_ADDI_X1_5, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5, 4'h0);
    send(32'h4, 32'h8, I_ADD_X2, 5'd1, 32'd6, 5'd1, 32'd7, 5'd2, 32'd13, 4'h0);
    idle();
    check_eq("rs1_prio_code", h_err_code, 3);

    // x0 write; continue-mode keeps counting (2-bit counter wraps) and x0 stays 0.
    do_reset();
    send(32'h0, 32'h4, I_ADDI_X1_5, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5, 4'h0);
    send(32'h4, 32'h8, I_ADDI_X0_1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd1, 4'h0);
    idle();
    check_eq("x0_h_code", h_err_code, 5);
    check_eq("x0_c_code", c_err_code, 5);
    check_eq("x0_c_count1", c_count, 1);
    send(32'h8,  32'hC,  I_ADDI_X1_5, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5, 4'h0);
    send(32'hC,  32'h10, I_ADDI_X1_5, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5, 4'h0);
    send(32'h10, 32'h14, I_ADDI_X1_5, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5, 4'h0);
    idle();
    check_eq("x0_c_count_wrap", c_count, 0);
    check_eq("x0_c_code_kept", c_err_code, 5);
    check_eq("x0_c_pc_kept", c_err_pc, 32'h4);
    check_eq("x0_h_count", h_count, 1);

    // Misaligned next PC.
    do_reset();
    send(32'h0, 32'h6, I_NOP, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 4'h0);
    idle();
    check_eq("misalign_code", h_err_code, 6);

    // Mid-stream reset with a packet in flight, then bad start PC.
    do_reset();
    send(32'h0, 32'h4, I_ADDI_X1_5, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd5, 4'h0);
    send(32'h4, 32'h8, I_ADD_X2, 5'd1, 32'd5, 5'd1, 32'd5, 5'd2, 32'd10, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    rvfi_pc_rdata = 32'h8; rvfi_pc_wdata = 32'hC; rvfi_insn = I_ADDI_X1_5;
    rvfi_rs1_addr = 5'd0; rvfi_rs1_rdata = 32'd0; rvfi_rd_addr = 5'd1; rvfi_rd_wdata = 32'd5;
    @(negedge clk);
    rst = 1'b1; rvfi_valid = 1'b0;
    check_eq("midrst_h_count", h_count, 0);
    check_eq("midrst_h_errv", h_err_valid, 0);
    send(32'h100, 32'h104, I_NOP, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 4'h0);
    idle();
    check_eq("start_h_code", h_err_code, 1);
    check_eq("start_h_pc", h_err_pc, 32'h100);
    check_eq("start_c_code", c_err_code, 1);
    // Shadow x1/x2 must read zero again after reset.
    send(32'h0, 32'h4, I_ADD_X3, 5'd1, 32'd0, 5'd2, 32'd0, 5'd3, 32'd0, 4'h0);
    idle();
    check_eq("shadow_clr_c_count", c_count, 1);

    // Store byte mask.
    do_reset();
    send(32'h0, 32'h4, I_SW, 5'd2, 32'd0, 5'd1, 32'd0, 5'd0, 32'd0, 4'b0111);
    idle();
`ifdef RVFI_CHK_MEM_EN
    check_eq("mem_h_code", h_err_code, 7);
    check_eq("mem_h_count", h_count, 0);
`else
    check_eq("mem_h_errv", h_err_valid, 0);
    check_eq("mem_h_count", h_count, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
